// File: rtl/data_memory_responder.sv
// Data-port responder for the pipeline M stage: one outstanding word/byte access,
// a fixed number of wait states, a single-cycle ready pulse and a pipeline stall.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no access in flight; a read/write request is accepted here
// ST_WAIT    | access latched, wait counter running down to the commit edge
// ST_RESPOND | access committed; ready (and misaligned if set) pulse this cycle
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memoryRead,
    input  logic        memoryWrite,
    input  logic        byteMode,
    input  logic [15:0] address,
    input  logic [15:0] dataWrite,
    output logic [15:0] dataRead,
    output logic        ready,
    output logic        stall,
    output logic        misaligned
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic accept, commit;

    // Latched request; only the byte-address bits that reach the array are kept.
    logic             lat_write;
    logic             lat_byte;
    logic [IDX_W:0]   lat_addr;
    logic [15:0]      lat_data;
    logic             lat_mis;

    logic [15:0] mem [DEPTH_WORDS];

    logic             req;
    logic             acc_write;
    logic             acc_byte;
    logic [IDX_W:0]   acc_addr;
    logic [15:0]      acc_data;
    logic             acc_mis;
    logic [IDX_W-1:0] acc_idx;
    logic [15:0]      acc_word;
    logic [7:0]       acc_lane;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[15:IDX_W+1];

    assign req = memoryRead | memoryWrite;

    // Operands for the commit edge. With zero wait states the commit edge is the
    // accept edge, so the live inputs stand in for the values being latched there.
    always_comb begin
        acc_write = lat_write;
        acc_byte  = lat_byte;
        acc_addr  = lat_addr;
        acc_data  = lat_data;
        if (state == ST_IDLE) begin
            acc_write = memoryWrite;
            acc_byte  = byteMode;
            acc_addr  = address[IDX_W:0];
            acc_data  = dataWrite;
        end
        acc_mis  = ~acc_byte & acc_addr[0];
        acc_idx  = acc_addr[IDX_W:1];
        acc_word = mem[acc_idx];
        // Big-endian lanes: even byte address is the high byte.
        acc_lane = acc_addr[0] ? acc_word[7:0] : acc_word[15:8];
    end

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        commit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_RESPOND;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_RESPOND;
                    commit    = 1'b1;
                end
            end
            ST_RESPOND: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stall      = ((state == ST_IDLE) & req) | (state == ST_WAIT);
    assign ready      = (state == ST_RESPOND);
    assign misaligned = (state == ST_RESPOND) & lat_mis;

    // State, request latch, memory array and read-data register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            dataRead  <= '0;
            lat_write <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_mis   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                lat_write <= memoryWrite;
                lat_byte  <= byteMode;
                lat_addr  <= address[IDX_W:0];
                lat_data  <= dataWrite;
                lat_mis   <= ~byteMode & address[0];
            end
            if (commit) begin
                // A misaligned word access touches nothing but clears the read data.
                if (acc_mis) begin
                    dataRead <= '0;
                end else if (acc_write) begin
                    if (acc_byte) begin
                        if (acc_addr[0]) begin
                            mem[acc_idx][7:0] <= acc_data[7:0];
                        end else begin
                            mem[acc_idx][15:8] <= acc_data[7:0];
                        end
                    end else begin
                        mem[acc_idx] <= acc_data;
                    end
                end else if (acc_byte) begin
                    dataRead <= {8'h00, acc_lane};
                end else begin
                    dataRead <= acc_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) driven by
// directed and random accesses, scored against a word-array reference model.
module tb_data_memory_responder;

    localparam int W0 = 2;
    localparam int W1 = 0;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        rd    [2];
    logic        wr    [2];
    logic        bm    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdat  [2];
    logic [15:0] rdat  [2];
    logic        rdy   [2];
    logic        stl   [2];
    logic        mis   [2];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] data;
        logic        mis;
        int          issue;
    } exp_t;

    exp_t        exp_q [2][$];
    logic [15:0] ref_mem [2][256];
    logic [15:0] ref_dr [2];
    int          stall_cnt [2];

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(W0)) dut0 (
        .clk(clk), .reset_n(rst_n[0]), .memoryRead(rd[0]), .memoryWrite(wr[0]),
        .byteMode(bm[0]), .address(addr[0]), .dataWrite(wdat[0]), .dataRead(rdat[0]),
        .ready(rdy[0]), .stall(stl[0]), .misaligned(mis[0])
    );

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(W1)) dut1 (
        .clk(clk), .reset_n(rst_n[1]), .memoryRead(rd[1]), .memoryWrite(wr[1]),
        .byteMode(bm[1]), .address(addr[1]), .dataWrite(wdat[1]), .dataRead(rdat[1]),
        .ready(rdy[1]), .stall(stl[1]), .misaligned(mis[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic check(input string name, input int d, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 256; i++) ref_mem[d][i] = 16'h0000;
        ref_dr[d] = 16'h0000;
    endtask

    // Reference behaviour of one access; pushes the response the DUT must give.
    task automatic expect_acc(input int d, input bit w, input bit b,
                              input logic [15:0] a, input logic [15:0] wd, input int ic);
        int idx;
        bit m;
        idx = int'(a[8:1]);
        m = !b && a[0];
        if (m) begin
            ref_dr[d] = 16'h0000;
        end else if (w) begin
            if (!b)       ref_mem[d][idx] = wd;
            else if (a[0]) ref_mem[d][idx][7:0] = wd[7:0];
            else           ref_mem[d][idx][15:8] = wd[7:0];
        end else if (b) begin
            ref_dr[d] = {8'h00, a[0] ? ref_mem[d][idx][7:0] : ref_mem[d][idx][15:8]};
        end else begin
            ref_dr[d] = ref_mem[d][idx];
        end
        exp_q[d].push_back('{ref_dr[d], m, ic});
    endtask

    task automatic drive(input int d, input bit r, input bit w, input bit b,
                         input logic [15:0] a, input logic [15:0] wd);
        rd[d] = r; wr[d] = w; bm[d] = b; addr[d] = a; wdat[d] = wd;
    endtask

    task automatic drive_idle(input int d);
        drive(d, 1'b0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_ready(input int d);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                seen = 1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ready_timeout dut%0d: no ready within 40 cycles (cycle %0d)", d, cyc);
        end
        @(posedge clk); #1;
    endtask

    // Called one step after a rising edge with the DUT idle.
    task automatic access(input int d, input bit r, input bit w, input bit b,
                          input logic [15:0] a, input logic [15:0] wd);
        drive(d, r, w, b, a, wd);
        expect_acc(d, w, b, a, wd, cyc);
        @(posedge clk); #1;
        drive_idle(d);
        wait_ready(d);
    endtask

    // Second request is held from the cycle after acceptance onward; it must be
    // ignored through WAIT and RESPOND and taken in the following IDLE cycle.
    task automatic access_b2b(input int d, input bit w1, input bit b1, input logic [15:0] a1,
                              input logic [15:0] wd1, input bit w2, input bit b2,
                              input logic [15:0] a2, input logic [15:0] wd2);
        drive(d, !w1, w1, b1, a1, wd1);
        expect_acc(d, w1, b1, a1, wd1, cyc);
        @(posedge clk); #1;
        drive(d, !w2, w2, b2, a2, wd2);
        expect_acc(d, w2, b2, a2, wd2, cyc + 1 + ws(d));
        repeat (ws(d) + 2) @(posedge clk);
        #1;
        drive_idle(d);
        wait_ready(d);
    endtask

    task automatic pulse_reset(input int d);
        rst_n[d] = 1'b0;
        @(posedge clk); #1;
        rst_n[d] = 1'b1;
        model_reset(d);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n[d]) begin
                    stall_cnt[d] = 0;
                end else if (rdy[d]) begin
                    if (exp_q[d].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ready dut%0d: ready=1, expected no response (cycle %0d)", d, cyc);
                    end else begin
                        e = exp_q[d].pop_front();
                        check("dataRead", d, rdat[d], e.data);
                        check("misaligned", d, 16'(mis[d]), 16'(e.mis));
                        check("latency", d, 16'(cyc - e.issue), 16'(1 + ws(d)));
                        check("stall_cycles", d, 16'(stall_cnt[d]), 16'(1 + ws(d)));
                        check("stall_in_respond", d, 16'(stl[d]), 16'h0);
                    end
                    stall_cnt[d] = 0;
                end else begin
                    if (stl[d]) stall_cnt[d]++;
                    check("misaligned_idle", d, 16'(mis[d]), 16'h0);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            drive_idle(d);
            stall_cnt[d] = 0;
            model_reset(d);
        end
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check("reset_dataRead", d, rdat[d], 16'h0000);
            check("reset_ready", d, 16'(rdy[d]), 16'h0);
            check("reset_misaligned", d, 16'(mis[d]), 16'h0);
            check("reset_stall", d, 16'(stl[d]), 16'h0);
        end

        // Word write then read back.
        access(0, 0, 1, 0, 16'h0010, 16'hBEEF);
        access(0, 1, 0, 0, 16'h0010, 16'h0000);
        // Byte lanes.
        access(0, 0, 1, 0, 16'h0020, 16'h1234);
        access(0, 0, 1, 1, 16'h0021, 16'h55AB);
        access(0, 1, 0, 0, 16'h0020, 16'h0000);
        access(0, 1, 0, 1, 16'h0020, 16'h0000);
        // Misaligned word read leaves the neighbouring word alone.
        access(0, 0, 1, 0, 16'h0030, 16'h4321);
        access(0, 1, 0, 0, 16'h0031, 16'h0000);
        access(0, 1, 0, 0, 16'h0030, 16'h0000);
        // Reset during WAIT aborts the write and suppresses ready.
        drive(0, 0, 1, 0, 16'h0040, 16'h5555);
        @(posedge clk); #1;
        drive_idle(0);
        @(posedge clk); #1;
        pulse_reset(0);
        repeat (4) @(posedge clk);
        #1;
        access(0, 1, 0, 0, 16'h0040, 16'h0000);
        // Read and write together is a write only.
        access(0, 1, 0, 0, 16'h0010, 16'h0000);
        access(0, 1, 1, 0, 16'h0050, 16'h7777);
        access(0, 1, 0, 0, 16'h0050, 16'h0000);
        // Back-to-back with a request held through RESPOND.
        access_b2b(0, 1, 0, 16'h0060, 16'hCAFE, 0, 0, 16'h0060, 16'h0000);

        // Zero wait states and address aliasing.
        access(1, 0, 1, 0, 16'h0200, 16'hA5A5);
        access(1, 1, 0, 0, 16'h0000, 16'h0000);
        access(1, 1, 0, 1, 16'h0401, 16'h0000);
        access_b2b(1, 1, 1, 16'h0003, 16'h00C3, 0, 0, 16'h0002, 16'h0000);

        // Random traffic on a small alias-rich address window.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                bit w, b, both, w2, b2;
                logic [15:0] a, a2;
                logic [15:0] wd, wd2;
                int op;
                op = int'($urandom_range(0, 2));
                w = (op != 0);
                both = (op == 2);
                b = 1'($urandom);
                a = {7'($urandom), 3'b000, 6'($urandom)};
                wd = 16'($urandom);
                if (w && !b) a[0] = 1'b0;
                if ($urandom_range(0, 4) == 0) begin
                    w2 = 1'($urandom);
                    b2 = 1'($urandom);
                    a2 = {7'($urandom), 3'b000, 6'($urandom)};
                    wd2 = 16'($urandom);
                    if (w2 && !b2) a2[0] = 1'b0;
                    access_b2b(d, w, b, a, wd, w2, b2, a2, wd2);
                end else begin
                    access(d, !w || both, w, b, a, wd);
                end
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("pending_responses", 0, 16'(exp_q[0].size()), 16'h0);
        check("pending_responses", 1, 16'(exp_q[1].size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
